// File: rtl/id_stage.sv
// Decode stage of the 16-bit 5-stage pipeline.
// Holds the 8x16 register file, detects load-use and branch hazards, resolves
// BEQ/BNE/J in ID, drives IF stall/flush/redirect and registers ID/EX.
// Optional feature: define ID_BRANCH_FWD_EN to forward the EX/MEM ALU result
// into the branch comparator; without it that case stalls one cycle instead.
module id_stage #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 8,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     instr_i,
    input  logic [ADDR_WIDTH-1:0]     PCD_i,
    input  logic                      wb_we_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_i,
    input  logic                      exmem_we_i,
    input  logic                      exmem_ld_i,
    input  logic [DATA_WIDTH-1:0]     exmem_alu_i,
    output logic                      PC_src_o,
    output logic [ADDR_WIDTH-1:0]     branchAddr_o,
    output logic                      jump_o,
    output logic [ADDR_WIDTH-1:0]     jumpAddr_o,
    output logic                      flushIF_ID_o,
    output logic                      stallIF_ID_o,
    output logic                      stallPC_o,
    output logic [5:0]                idex_ctrl_o,
    output logic [DATA_WIDTH-1:0]     idex_rs_data_o,
    output logic [DATA_WIDTH-1:0]     idex_rt_data_o,
    output logic [DATA_WIDTH-1:0]     idex_imm_o,
    output logic [REG_ADDR_WIDTH-1:0] idex_rs_o,
    output logic [REG_ADDR_WIDTH-1:0] idex_rt_o,
    output logic [REG_ADDR_WIDTH-1:0] idex_rd_o
);
    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic [3:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd_f, rs_f, rt_f, b_idx;
    logic [DATA_WIDTH-1:0]     rf [NREG];
    logic [DATA_WIDTH-1:0]     rd_val, rs_val, rt_val, b_val, imm_ext;
    logic [DATA_WIDTH-1:0]     cmp_a, cmp_b;
    logic                      squash_q, kill, act;
    logic                      is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, is_br, valid;
    logic                      uses_rs, uses_rt, uses_rd;
    logic [5:0]                ctrl_dec;
    logic                      lu_hit, idex_cmp_hit, ld_cmp_hit, fwd_a, fwd_b, alu_stall;
    logic                      stall, taken;

    assign op   = instr_i[15:12];
    assign rd_f = instr_i[11:9];
    assign rs_f = instr_i[8:6];
    assign rt_f = instr_i[5:3];

    assign imm_ext      = {{(DATA_WIDTH-6){instr_i[5]}}, instr_i[5:0]};
    assign branchAddr_o = PCD_i + {{(ADDR_WIDTH-6){instr_i[5]}}, instr_i[5:0]};
    assign jumpAddr_o   = instr_i[ADDR_WIDTH-1:0];

    // Register file: writeback port, r0 never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (wb_we_i && wb_rd_i != '0) begin
            rf[wb_rd_i] <= wb_data_i;
        end
    end

    // Write-first reads so a same-cycle writeback is visible in ID
    assign rd_val = (rd_f == '0) ? '0 : (wb_we_i && wb_rd_i == rd_f) ? wb_data_i : rf[rd_f];
    assign rs_val = (rs_f == '0) ? '0 : (wb_we_i && wb_rd_i == rs_f) ? wb_data_i : rf[rs_f];
    assign rt_val = (rt_f == '0) ? '0 : (wb_we_i && wb_rd_i == rt_f) ? wb_data_i : rf[rt_f];

    // Opcode decode: control word and which register fields are read
    always_comb begin
        is_r = 1'b0; is_addi = 1'b0; is_lw = 1'b0; is_sw = 1'b0;
        is_beq = 1'b0; is_bne = 1'b0; is_j = 1'b0;
        ctrl_dec = 6'b000000;
        case (op)
            4'd0: begin is_r    = 1'b1; ctrl_dec = 6'b100010; end
            4'd1: begin is_addi = 1'b1; ctrl_dec = 6'b100100; end
            4'd2: begin is_lw   = 1'b1; ctrl_dec = 6'b110100; end
            4'd3: begin is_sw   = 1'b1; ctrl_dec = 6'b001100; end
            4'd4: begin is_beq  = 1'b1; ctrl_dec = 6'b000001; end
            4'd5: begin is_bne  = 1'b1; ctrl_dec = 6'b000001; end
            4'd6: begin is_j    = 1'b1; end
            default: ;
        endcase
    end

    assign is_br   = is_beq | is_bne;
    assign valid   = is_r | is_addi | is_lw | is_sw | is_br | is_j;
    assign uses_rs = is_r | is_addi | is_lw | is_sw | is_br;
    assign uses_rt = is_r;
    assign uses_rd = is_sw | is_br;

    // Operand B carries store data for SW and the rd compare operand for branches
    assign b_idx = uses_rd ? rd_f : rt_f;
    assign b_val = uses_rd ? rd_val : rt_val;

    // Squashed, invalid or in-reset instructions behave as NOP
    assign kill = squash_q | ~valid | ~rst_n;
    assign act  = ~kill;

    assign lu_hit = idex_ctrl_o[4] && idex_rd_o != '0 &&
                    ((uses_rs && idex_rd_o == rs_f) || (uses_rt && idex_rd_o == rt_f) ||
                     (uses_rd && idex_rd_o == rd_f));
    assign idex_cmp_hit = is_br && idex_ctrl_o[5] && idex_rd_o != '0 &&
                          (idex_rd_o == rd_f || idex_rd_o == rs_f);
    assign ld_cmp_hit = is_br && exmem_ld_i && exmem_rd_i != '0 &&
                        (exmem_rd_i == rd_f || exmem_rd_i == rs_f);

    // EX/MEM ALU result matching a compared register; EX/MEM is newer than WB
    assign fwd_a = exmem_we_i && !exmem_ld_i && exmem_rd_i != '0 && exmem_rd_i == rd_f;
    assign fwd_b = exmem_we_i && !exmem_ld_i && exmem_rd_i != '0 && exmem_rd_i == rs_f;
    assign cmp_a = fwd_a ? exmem_alu_i : rd_val;
    assign cmp_b = fwd_b ? exmem_alu_i : rs_val;

`ifdef ID_BRANCH_FWD_EN
    assign alu_stall = 1'b0;
`else
    // Forwarded value is not trusted here; the stall masks the comparison
    assign alu_stall = is_br & (fwd_a | fwd_b);
`endif

    assign stall = act & (lu_hit | idex_cmp_hit | ld_cmp_hit | alu_stall);
    assign taken = (is_beq & (cmp_a == cmp_b)) | (is_bne & (cmp_a != cmp_b));

    assign stallIF_ID_o = stall;
    assign stallPC_o    = stall;
    assign PC_src_o     = act & ~stall & taken;
    assign jump_o       = act & ~stall & is_j;
    assign flushIF_ID_o = PC_src_o | jump_o;

    // Squash marks the wrong-path instruction fetched behind a redirect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) squash_q <= 1'b0;
        else        squash_q <= flushIF_ID_o & ~stall;
    end

    // ID/EX pipeline register: bubble on stall or NOP, decoded fields otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_ctrl_o    <= '0;
            idex_rs_data_o <= '0;
            idex_rt_data_o <= '0;
            idex_imm_o     <= '0;
            idex_rs_o      <= '0;
            idex_rt_o      <= '0;
            idex_rd_o      <= '0;
        end else if (stall || kill) begin
            idex_ctrl_o    <= '0;
            idex_rs_data_o <= '0;
            idex_rt_data_o <= '0;
            idex_imm_o     <= '0;
            idex_rs_o      <= '0;
            idex_rt_o      <= '0;
            idex_rd_o      <= '0;
        end else begin
            idex_ctrl_o    <= ctrl_dec;
            idex_rs_data_o <= rs_val;
            idex_rt_data_o <= b_val;
            idex_imm_o     <= imm_ext;
            idex_rs_o      <= rs_f;
            idex_rt_o      <= b_idx;
            idex_rd_o      <= rd_f;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: a reference model computes expected
// combinational outputs and next ID/EX contents per cycle; a monitor compares.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic [7:0]  pcd;
    logic        wb_we;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [2:0]  ex_rd;
    logic        ex_we, ex_ld;
    logic [15:0] ex_alu;
    logic        pc_src, jump, flush, stall_ifid, stall_pc;
    logic [7:0]  baddr, jaddr;
    logic [5:0]  ctrl;
    logic [15:0] rs_data, rt_data, imm;
    logic [2:0]  rs_idx, rt_idx, rd_idx;

    id_stage dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .PCD_i(pcd),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .exmem_rd_i(ex_rd), .exmem_we_i(ex_we), .exmem_ld_i(ex_ld), .exmem_alu_i(ex_alu),
        .PC_src_o(pc_src), .branchAddr_o(baddr), .jump_o(jump), .jumpAddr_o(jaddr),
        .flushIF_ID_o(flush), .stallIF_ID_o(stall_ifid), .stallPC_o(stall_pc),
        .idex_ctrl_o(ctrl), .idex_rs_data_o(rs_data), .idex_rt_data_o(rt_data),
        .idex_imm_o(imm), .idex_rs_o(rs_idx), .idex_rt_o(rt_idx), .idex_rd_o(rd_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc_src;
        logic [7:0]  baddr;
        logic        jump;
        logic [7:0]  jaddr;
        logic        stall;
        logic [5:0]  ctrl;
        logic [15:0] rsd, rtd, imm;
        logic [2:0]  rs, rt, rd;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // reference model state
    logic [15:0] m_rf [8];
    logic [5:0]  m_ctrl;
    logic [2:0]  m_rd;
    bit          m_sq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] i);
        if (i == 3'd0) return 16'h0;
        if (wb_we && wb_rd == i) return wb_data;
        return m_rf[i];
    endfunction

    function automatic logic [5:0] ctrl_of(input int o);
        case (o)
            0: return 6'b100010;
            1: return 6'b100100;
            2: return 6'b110100;
            3: return 6'b001100;
            4, 5: return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [15:0] mk(input int o, input int d, input int s, input int t);
        return 16'((o << 12) | (d << 9) | (s << 6) | (t << 3));
    endfunction

    function automatic logic [15:0] mki(input int o, input int d, input int s, input int im);
        return 16'((o << 12) | (d << 9) | (s << 6) | (im & 63));
    endfunction

    function automatic exp_t model(input bit r);
        exp_t e;
        int   o, d, s, t, bi;
        int   srcs[$];
        bit   hz, br, tk;
        logic [15:0] a, b;
        o = int'(instr[15:12]); d = int'(instr[11:9]); s = int'(instr[8:6]); t = int'(instr[5:3]);
        e = '{pc_src: 0, baddr: pcd + {{2{instr[5]}}, instr[5:0]}, jump: 0, jaddr: instr[7:0],
              stall: 0, ctrl: 0, rsd: 0, rtd: 0, imm: 0, rs: 0, rt: 0, rd: 0};
        if (!r) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 16'h0;
            m_ctrl = 0; m_rd = 0; m_sq = 0;
            return e;
        end
        if (!m_sq && o <= 6) begin
            br = (o == 4 || o == 5);
            case (o)
                0: srcs = '{s, t};
                1, 2: srcs = '{s};
                3, 4, 5: srcs = '{s, d};
                default: srcs = {};
            endcase
            hz = 0;
            foreach (srcs[k]) begin
                if (m_ctrl[4] && m_rd != 0 && int'(m_rd) == srcs[k]) hz = 1;
                if (br) begin
                    if (m_ctrl[5] && m_rd != 0 && int'(m_rd) == srcs[k]) hz = 1;
                    if (ex_rd != 0 && int'(ex_rd) == srcs[k]) begin
                        if (ex_ld) hz = 1;
`ifndef ID_BRANCH_FWD_EN
                        else if (ex_we) hz = 1;
`endif
                    end
                end
            end
            a = (ex_we && !ex_ld && ex_rd != 0 && int'(ex_rd) == d) ? ex_alu : m_read(3'(d));
            b = (ex_we && !ex_ld && ex_rd != 0 && int'(ex_rd) == s) ? ex_alu : m_read(3'(s));
            tk = (o == 4) ? (a == b) : (a != b);
            e.stall  = hz;
            e.pc_src = !hz && br && tk;
            e.jump   = !hz && o == 6;
            if (!hz) begin
                bi = (o >= 3 && o <= 5) ? d : t;
                e.ctrl = ctrl_of(o);
                e.rs = 3'(s); e.rt = 3'(bi); e.rd = 3'(d);
                e.rsd = m_read(3'(s)); e.rtd = m_read(3'(bi));
                e.imm = {{10{instr[5]}}, instr[5:0]};
            end
        end
        m_sq = e.pc_src | e.jump;
        if (wb_we && wb_rd != 0) m_rf[wb_rd] = wb_data;
        m_ctrl = e.ctrl;
        m_rd   = e.rd;
        return e;
    endfunction

    task automatic step(input bit r, input logic [15:0] ins, input logic [7:0] pc,
                        input bit wwe, input int wrd, input logic [15:0] wd,
                        input int erd, input bit ewe, input bit eld, input logic [15:0] ea);
        @(negedge clk);
        rst_n = r; instr = ins; pcd = pc;
        wb_we = wwe; wb_rd = 3'(wrd); wb_data = wd;
        ex_rd = 3'(erd); ex_we = ewe; ex_ld = eld; ex_alu = ea;
        sbq.push_back(model(r));
    endtask

    task automatic plain(input logic [15:0] ins, input logic [7:0] pc);
        step(1, ins, pc, 0, 0, 16'h0, 0, 0, 0, 16'h0);
    endtask

    task automatic wb(input int rr, input logic [15:0] v);
        step(1, 16'hF000, 8'h00, 1, rr, v, 0, 0, 0, 16'h0);
    endtask

    // monitor: combinational outputs mid-cycle, ID/EX after the next edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("pc_src", 32'(pc_src), 32'(e.pc_src));
                chk("branch_addr", 32'(baddr), 32'(e.baddr));
                chk("jump", 32'(jump), 32'(e.jump));
                chk("jump_addr", 32'(jaddr), 32'(e.jaddr));
                chk("flush", 32'(flush), 32'(e.pc_src | e.jump));
                chk("stall_ifid", 32'(stall_ifid), 32'(e.stall));
                chk("stall_pc", 32'(stall_pc), 32'(e.stall));
                @(posedge clk);
                #1;
                chk("idex_ctrl", 32'(ctrl), 32'(e.ctrl));
                chk("idex_rs_data", 32'(rs_data), 32'(e.rsd));
                chk("idex_rt_data", 32'(rt_data), 32'(e.rtd));
                chk("idex_imm", 32'(imm), 32'(e.imm));
                chk("idex_rs", 32'(rs_idx), 32'(e.rs));
                chk("idex_rt", 32'(rt_idx), 32'(e.rt));
                chk("idex_rd", 32'(rd_idx), 32'(e.rd));
            end
        end
    end

    initial begin
        rst_n = 0; instr = 0; pcd = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
        ex_rd = 0; ex_we = 0; ex_ld = 0; ex_alu = 0;
        repeat (2) step(0, 16'h0, 8'h0, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        wb(1, 16'h0005);
        wb(2, 16'h0009);
        // same-cycle writeback of r3 read by ADD r4,r3,r1
        step(1, mk(0, 4, 3, 1), 8'h10, 1, 3, 16'h1234, 0, 0, 0, 16'h0);
        // LW r2 then dependent ADD: one stall, then issue
        plain(mki(2, 2, 1, 0), 8'h11);
        plain(mk(0, 4, 2, 1), 8'h12);
        plain(mk(0, 4, 2, 1), 8'h12);
        // BEQ r1,r1,-2 at PC 0x01, following instruction squashed
        plain(16'hF000, 8'h00);
        plain(mki(4, 1, 1, -2), 8'h01);
        plain(mki(1, 5, 1, 3), 8'h02);
        plain(mki(1, 6, 1, 1), 8'hFF);
        // J 0x40, then a taken BEQ in the squashed slot
        plain(16'h6040, 8'h20);
        plain(mki(4, 1, 1, 4), 8'h41);
        plain(16'hF000, 8'h42);
        // ADDI r5 in EX/MEM, BNE r5,r0
        step(1, mki(5, 5, 0, 2), 8'h50, 0, 0, 16'h0, 5, 1, 0, 16'h0007);
        step(1, mki(5, 5, 0, 2), 8'h50, 1, 5, 16'h0007, 0, 0, 0, 16'h0);
        plain(16'hF000, 8'h52);
        // branch boundary: target wraps past 0xFF
        plain(mki(4, 0, 0, 1), 8'hFF);
        plain(16'hF000, 8'h00);
        // reset mid-run with ADDI in ID/EX, BEQ r0,r0 on the input
        plain(mki(1, 3, 1, 4), 8'h30);
        step(0, mki(4, 0, 0, 1), 8'h31, 1, 2, 16'hBEEF, 0, 0, 0, 16'h0);
        step(0, mki(4, 0, 0, 1), 8'h31, 0, 0, 16'h0, 0, 0, 0, 16'h0);
        plain(mk(0, 1, 2, 3), 8'h32);
        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [15:0] ri;
            ri = 16'($urandom);
            ri[15:12] = 4'($urandom_range(0, 7));
            step(($urandom_range(0, 199) != 0), ri, 8'($urandom),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)), 16'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 3) == 0), 16'($urandom_range(0, 3)));
        end
        plain(16'hF000, 8'h00);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
